// File: rtl/encin_qdec.sv
// encin_qdec - quadrature encoder input decoder.
//
// Samples the asynchronous A/B encoder lines through a 2-FF synchronizer,
// filters each line over pFILT clocks, and decodes the filtered pair 4x.
// Maintains a wrapping position, a saturating signed net edge count, the
// direction of the last edge, the clock period between the last two edges
// and a sticky illegal-transition flag.
//
// Parameters
//   pFILT          filter depth in clocks (1..15)
// Ports
//   i_pclk         clock, rising edge
//   i_presetn      asynchronous active-low reset
//   i_ence         decode enable
//   i_pol          direction polarity (1 inverts count direction)
//   i_posmax       position wrap limit, position range 0..i_posmax
//   i_load         pulse: load position from i_poscnt_init
//   i_poscnt_init  position load value
//   i_clr          pulse: clear o_edgecnt and o_err
//   i_enc_a/b      asynchronous encoder lines
//   o_poscnt       current position
//   o_edgecnt      signed net edge count
//   o_pdcnt        clocks between the last two valid edges
//   o_dir          direction of last valid edge, 1 = increment
//   o_edge         one-cycle pulse per valid edge
//   o_err          sticky illegal-transition flag
module encin_qdec #(
  parameter int pFILT = 3
) (
  input  logic        i_pclk,
  input  logic        i_presetn,
  input  logic        i_ence,
  input  logic        i_pol,
  input  logic [15:0] i_posmax,
  input  logic        i_load,
  input  logic [15:0] i_poscnt_init,
  input  logic        i_clr,
  input  logic        i_enc_a,
  input  logic        i_enc_b,
  output logic [15:0] o_poscnt,
  output logic [15:0] o_edgecnt,
  output logic [15:0] o_pdcnt,
  output logic        o_dir,
  output logic        o_edge,
  output logic        o_err
);

  localparam logic [3:0] FILT_LAST = 4'(pFILT - 1);

  // Bit 1 carries line A and bit 0 line B, so {A,B} reads naturally.
  logic [1:0]  sync1;
  logic [1:0]  sync2;
  logic [1:0]  filt;
  logic [1:0]  prev;
  logic [3:0]  cnt [2];
  logic [15:0] timer;

  logic        fwd;
  logic        rev;
  logic        illegal;
  logic        valid;
  logic        up;
  logic [15:0] pos_next;
  logic [15:0] edge_next;
  logic [15:0] timer_inc;

  // Synchronizer and per-line filter: a new level must persist for pFILT
  // consecutive clocks at the synchronizer output before it is accepted.
  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1 <= {i_enc_a, i_enc_b};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == FILT_LAST) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  // Gray-code step decode of previous vs current filtered state.
  always_comb begin
    fwd = 1'b0;
    rev = 1'b0;
    case ({prev, filt})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: rev = 1'b1;
      default: ;
    endcase
  end

  assign illegal = (prev ^ filt) == 2'b11;
  assign valid   = i_ence & (fwd | rev);
  assign up      = fwd ^ i_pol;

  // Next-value arithmetic: wrapping position, saturating edge count and
  // saturating period timer.
  always_comb begin
    pos_next  = o_poscnt;
    edge_next = o_edgecnt;
    if (up) begin
      pos_next = (o_poscnt >= i_posmax) ? 16'd0 : o_poscnt + 16'd1;
      if (o_edgecnt != 16'h7FFF) edge_next = o_edgecnt + 16'd1;
    end else begin
      pos_next = (o_poscnt == 16'd0) ? i_posmax : o_poscnt - 16'd1;
      if (o_edgecnt != 16'h8000) edge_next = o_edgecnt - 16'd1;
    end
    timer_inc = (timer == 16'hFFFF) ? 16'hFFFF : timer + 16'd1;
  end

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      prev      <= '0;
      timer     <= '0;
      o_poscnt  <= '0;
      o_edgecnt <= '0;
      o_pdcnt   <= '0;
      o_dir     <= 1'b0;
      o_edge    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      // prev tracks the filtered state even while disabled so that
      // re-enabling never produces a spurious step.
      prev   <= filt;
      o_edge <= valid;

      if (i_load) begin
        o_poscnt <= i_poscnt_init;
      end else if (valid) begin
        o_poscnt <= pos_next;
      end

      if (i_clr) begin
        o_edgecnt <= '0;
      end else if (valid) begin
        o_edgecnt <= edge_next;
      end

      // A same-cycle illegal transition beats the clear.
      if (i_ence && illegal) begin
        o_err <= 1'b1;
      end else if (i_clr) begin
        o_err <= 1'b0;
      end

      if (valid) o_dir <= up;

      if (!i_ence) begin
        timer <= '0;
      end else if (valid) begin
        o_pdcnt <= timer_inc;
        timer   <= '0;
      end else begin
        timer <= timer_inc;
      end
    end
  end

endmodule

// File: tb/tb_encin_qdec.sv
// tb_encin_qdec - self-checking bench for encin_qdec.
//
// Drives encoder patterns into a pFILT=3 instance and keeps a reference
// model of position, edge count, direction and period. Each valid edge
// pushes its expected result to a queue, popped when o_edge pulses.
// A second pFILT=1 instance is run at full edge rate to reach edge count
// saturation within a short run.
module tb_encin_qdec;

  localparam int P_NONE = 0;
  localparam int P_LOAD = 1;
  localparam int P_CLR  = 2;

  typedef struct {
    logic [15:0] pos;
    logic [15:0] ecnt;
    logic        dir;
    logic [15:0] pd;
    bit          pd_known;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ence = 1'b0;
  logic        pol = 1'b0;
  logic [15:0] posmax = 16'd9;
  logic        load = 1'b0;
  logic [15:0] poscnt_init = 16'd0;
  logic        clr = 1'b0;
  logic        enc_a = 1'b0;
  logic        enc_b = 1'b0;
  logic [15:0] poscnt;
  logic [15:0] edgecnt;
  logic [15:0] pdcnt;
  logic        dir;
  logic        edge_p;
  logic        err;

  logic        enc2_a = 1'b0;
  logic        enc2_b = 1'b0;
  logic [15:0] pos2;
  logic [15:0] ecnt2;
  logic [15:0] pd2;
  logic        dir2;
  logic        edge2;
  logic        err2;

  int          checks = 0;
  int          failures = 0;
  longint      cyc = 0;
  exp_t        sbq[$];
  exp_t        mon_e;

  logic [1:0]  m_pins = 2'b00;
  int          m_pos = 0;
  int          m_ecnt = 0;
  logic        m_dir = 1'b0;
  logic        m_err = 1'b0;
  bit          pd_known = 0;
  longint      last_cyc = 0;
  logic [1:0]  fwd_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  encin_qdec #(.pFILT(3)) dut (
    .i_pclk(clk), .i_presetn(rst_n), .i_ence(ence), .i_pol(pol),
    .i_posmax(posmax), .i_load(load), .i_poscnt_init(poscnt_init),
    .i_clr(clr), .i_enc_a(enc_a), .i_enc_b(enc_b),
    .o_poscnt(poscnt), .o_edgecnt(edgecnt), .o_pdcnt(pdcnt),
    .o_dir(dir), .o_edge(edge_p), .o_err(err)
  );

  encin_qdec #(.pFILT(1)) dut2 (
    .i_pclk(clk), .i_presetn(rst_n), .i_ence(1'b1), .i_pol(1'b0),
    .i_posmax(16'hFFFF), .i_load(1'b0), .i_poscnt_init(16'd0),
    .i_clr(1'b0), .i_enc_a(enc2_a), .i_enc_b(enc2_b),
    .o_poscnt(pos2), .o_edgecnt(ecnt2), .o_pdcnt(pd2),
    .o_dir(dir2), .o_edge(edge2), .o_err(err2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Position of a state along the forward cycle 00->10->11->01.
  function automatic int seq_idx(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Drives a new pin state, updates the model and, for a valid edge, queues
  // the expected result. An optional load/clear pulse lands on the same
  // clock as the resulting output update (6 clocks after the drive).
  task automatic applyStimulus(input logic [1:0] pins, input int hold,
                               input int pulse, input logic [15:0] load_val);
    int   d;
    bit   step_ok;
    logic up;
    exp_t e;
    d = (seq_idx(pins) - seq_idx(m_pins) + 4) % 4;
    step_ok = ence && (d == 1 || d == 3);
    e.pd = 16'd0;
    e.pd_known = 0;
    if (step_ok) begin
      up = (d == 1) ^ pol;
      if (up) m_pos = (m_pos >= int'(posmax)) ? 0 : m_pos + 1;
      else    m_pos = (m_pos == 0) ? int'(posmax) : m_pos - 1;
      if (up) begin
        if (m_ecnt < 32767) m_ecnt++;
      end else if (m_ecnt > -32768) begin
        m_ecnt--;
      end
      m_dir = up;
      e.pd_known = pd_known;
      e.pd = (cyc - last_cyc > 65535) ? 16'hFFFF : 16'(cyc - last_cyc);
      pd_known = 1;
      last_cyc = cyc;
    end
    if (pulse == P_LOAD) m_pos = int'(load_val);
    if (pulse == P_CLR) begin
      m_ecnt = 0;
      m_err = 1'b0;
    end
    if (ence && d == 2) m_err = 1'b1;
    if (step_ok) begin
      e.pos  = 16'(m_pos);
      e.ecnt = 16'(m_ecnt);
      e.dir  = m_dir;
      sbq.push_back(e);
    end
    m_pins = pins;
    {enc_a, enc_b} = pins;
    if (pulse != P_NONE) begin
      tick(5);
      poscnt_init = load_val;
      load = (pulse == P_LOAD);
      clr  = (pulse == P_CLR);
      tick(1);
      load = 1'b0;
      clr  = 1'b0;
      tick(hold - 6);
    end else begin
      tick(hold);
    end
  endtask

  // Scoreboard: every o_edge pulse must match the oldest queued edge.
  always @(negedge clk) begin
    if (rst_n && edge_p) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_edge", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        checkOutput("edge_pos", poscnt, mon_e.pos);
        checkOutput("edge_edgecnt", edgecnt, mon_e.ecnt);
        checkOutput("edge_dir", dir, mon_e.dir);
        if (mon_e.pd_known) checkOutput("edge_pdcnt", pdcnt, mon_e.pd);
      end
    end
  end

  initial begin : main
    int old_pos;
    tick(3);
    checkOutput("rst_poscnt", poscnt, 0);
    checkOutput("rst_edgecnt", edgecnt, 0);
    checkOutput("rst_pdcnt", pdcnt, 0);
    checkOutput("rst_dir", dir, 0);
    checkOutput("rst_edge", edge_p, 0);
    checkOutput("rst_err", err, 0);
    rst_n = 1'b1;
    ence = 1'b1;
    tick(5);

    // Forward rotation, 12 edges 20 clocks apart.
    for (int i = 0; i < 12; i++) applyStimulus(fwd_seq[i % 4], 20, P_NONE, 0);
    tick(10);
    checkOutput("fwd_poscnt", poscnt, 16'd2);
    checkOutput("fwd_edgecnt", edgecnt, 16'd12);
    checkOutput("fwd_dir", dir, 1'b1);
    checkOutput("fwd_pdcnt", pdcnt, 16'd20);

    // Reverse wrap from position 1.
    applyStimulus(m_pins, 10, P_LOAD, 16'd1);
    applyStimulus(m_pins, 10, P_CLR, 16'd0);
    applyStimulus(2'b01, 20, P_NONE, 0);
    applyStimulus(2'b11, 20, P_NONE, 0);
    applyStimulus(2'b10, 20, P_NONE, 0);
    checkOutput("rev_poscnt", poscnt, 16'd8);
    checkOutput("rev_edgecnt", edgecnt, 16'hFFFD);
    checkOutput("rev_dir", dir, 1'b0);

    // Same result with inverted polarity and forward rotation.
    pol = 1'b1;
    applyStimulus(m_pins, 10, P_LOAD, 16'd1);
    applyStimulus(m_pins, 10, P_CLR, 16'd0);
    applyStimulus(2'b11, 20, P_NONE, 0);
    applyStimulus(2'b01, 20, P_NONE, 0);
    applyStimulus(2'b00, 20, P_NONE, 0);
    checkOutput("pol_poscnt", poscnt, 16'd8);
    checkOutput("pol_edgecnt", edgecnt, 16'hFFFD);
    checkOutput("pol_dir", dir, 1'b0);
    pol = 1'b0;

    // Glitch of 2 clocks is rejected; 3 clocks is accepted with latency 6.
    enc_a = 1'b1;
    tick(2);
    enc_a = 1'b0;
    tick(15);
    checkOutput("glitch_poscnt", poscnt, 16'd8);
    old_pos = m_pos;
    applyStimulus(2'b10, 0, P_NONE, 0);
    tick(5);
    checkOutput("latency_before", poscnt, 16'(old_pos));
    tick(1);
    checkOutput("latency_at", poscnt, 16'd9);
    tick(14);

    // Illegal transition, clear, and illegal together with clear.
    applyStimulus(2'b01, 20, P_NONE, 0);
    checkOutput("illegal_err", err, 1'b1);
    checkOutput("illegal_poscnt", poscnt, 16'd9);
    applyStimulus(m_pins, 10, P_CLR, 16'd0);
    checkOutput("clr_err", err, 1'b0);
    checkOutput("clr_edgecnt", edgecnt, 16'd0);
    applyStimulus(2'b10, 10, P_CLR, 16'd0);
    checkOutput("clr_vs_illegal_err", err, m_err);

    // Load in the same cycle as a forward edge wins on position.
    applyStimulus(2'b11, 20, P_LOAD, 16'd5);
    checkOutput("load_prio_poscnt", poscnt, 16'd5);
    checkOutput("load_prio_edgecnt", edgecnt, 16'd1);

    // Disabled decode freezes everything.
    ence = 1'b0;
    tick(2);
    applyStimulus(2'b01, 10, P_NONE, 0);
    applyStimulus(2'b00, 10, P_NONE, 0);
    tick(10);
    checkOutput("dis_poscnt", poscnt, 16'd5);
    checkOutput("dis_edgecnt", edgecnt, 16'd1);
    ence = 1'b1;
    pd_known = 0;
    tick(5);
    applyStimulus(2'b10, 20, P_NONE, 0);

    // Long idle saturates the period timer; meanwhile the fast instance
    // drives the edge count into positive saturation.
    fork
      tick(70000);
      begin
        for (int i = 0; i < 32800; i++) begin
          {enc2_a, enc2_b} = fwd_seq[i % 4];
          tick(1);
        end
        tick(10);
        checkOutput("sat_edgecnt", ecnt2, 16'h7FFF);
        checkOutput("sat_poscnt", pos2, 16'd32800);
        checkOutput("sat_pdcnt", pd2, 16'd1);
        checkOutput("sat_err", err2, 1'b0);
      end
    join
    applyStimulus(2'b11, 20, P_NONE, 0);
    checkOutput("idle_pdcnt", pdcnt, 16'hFFFF);
    applyStimulus(2'b01, 20, P_NONE, 0);
    checkOutput("after_idle_pdcnt", pdcnt, 16'd20);

    // Asynchronous reset mid-run, with an edge still in flight.
    applyStimulus(2'b00, 3, P_NONE, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_poscnt", poscnt, 0);
    checkOutput("arst_edgecnt", edgecnt, 0);
    checkOutput("arst_pdcnt", pdcnt, 0);
    checkOutput("arst_dir", dir, 0);
    checkOutput("arst_edge", edge_p, 0);
    checkOutput("arst_err", err, 0);
    sbq.delete();
    m_pins = 2'b00;
    {enc_a, enc_b} = 2'b00;
    m_pos = 0;
    m_ecnt = 0;
    m_dir = 1'b0;
    m_err = 1'b0;
    pd_known = 0;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    applyStimulus(2'b10, 20, P_NONE, 0);
    checkOutput("post_rst_poscnt", poscnt, 16'd1);
    checkOutput("post_rst_edgecnt", edgecnt, 16'd1);
    checkOutput("queue_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
